// File: rtl/sc_level_sequencer.sv
// Level/progress sequencer for the Frogger core: owns level and progress,
// walks the frog through NUM_LEVELS levels and flags level and game completion.
module sc_level_sequencer #(
    parameter int NUM_LEVELS  = 3,
    parameter int LEVEL_WIDTH = 3,
    parameter int PROG_WIDTH  = 5,
    parameter int PROG_TARGET = 20
) (
    input  logic                   SC_LEVEL_SEQ_CLOCK_50,
    input  logic                   SC_LEVEL_SEQ_RESET_InHigh,
    input  logic                   SC_LEVEL_SEQ_Start_InLow,
    input  logic                   SC_LEVEL_SEQ_T0_InLow,
    input  logic                   SC_LEVEL_SEQ_Pause_InLow,
    input  logic                   SC_LEVEL_SEQ_Death_InLow,
    output logic [LEVEL_WIDTH-1:0] SC_LEVEL_SEQ_Level_Out,
    output logic [PROG_WIDTH-1:0]  SC_LEVEL_SEQ_Progress_Out,
    output logic                   SC_LEVEL_SEQ_ProgressUpCount_out,
    output logic                   SC_LEVEL_SEQ_LevelFinished_Out,
    output logic                   SC_LEVEL_SEQ_FinishedGame_Out
);

    localparam logic [2:0] STATE_IDLE    = 3'd0;
    localparam logic [2:0] STATE_PLAY    = 3'd1;
    localparam logic [2:0] STATE_SHIFT   = 3'd2;
    localparam logic [2:0] STATE_CLEAR   = 3'd3;
    localparam logic [2:0] STATE_DONE    = 3'd4;
    localparam logic [2:0] STATE_ENDGAME = 3'd5;

    localparam logic [LEVEL_WIDTH-1:0] lastLevel  = LEVEL_WIDTH'(NUM_LEVELS);
    localparam logic [LEVEL_WIDTH-1:0] firstLevel = LEVEL_WIDTH'(1);
    localparam logic [PROG_WIDTH-1:0]  progTarget = PROG_WIDTH'(PROG_TARGET);
    localparam logic [PROG_WIDTH-1:0]  progOne    = PROG_WIDTH'(1);

    logic [2:0]             state;
    logic [LEVEL_WIDTH-1:0] level;
    logic [PROG_WIDTH-1:0]  progress;

    always_ff @(posedge SC_LEVEL_SEQ_CLOCK_50) begin
        if (SC_LEVEL_SEQ_RESET_InHigh) begin
            state    <= STATE_IDLE;
            level    <= '0;
            progress <= '0;
        end else begin
            case (state)
                STATE_IDLE, STATE_ENDGAME: begin
                    if (!SC_LEVEL_SEQ_Start_InLow) begin
                        state    <= STATE_PLAY;
                        level    <= firstLevel;
                        progress <= '0;
                    end
                end
                STATE_PLAY: begin
                    // Death beats pause, pause beats the tick.
                    if (!SC_LEVEL_SEQ_Death_InLow) begin
                        state <= STATE_CLEAR;
                    end else if (SC_LEVEL_SEQ_Pause_InLow && !SC_LEVEL_SEQ_T0_InLow) begin
                        state    <= STATE_SHIFT;
                        progress <= progress + progOne;
                    end
                end
                STATE_SHIFT: begin
                    state <= (progress == progTarget) ? STATE_DONE : STATE_PLAY;
                end
                STATE_CLEAR: begin
                    state    <= STATE_PLAY;
                    progress <= '0;
                end
                STATE_DONE: begin
                    // Last level keeps its final level/progress on display in ENDGAME.
                    if (level == lastLevel) begin
                        state <= STATE_ENDGAME;
                    end else begin
                        state    <= STATE_PLAY;
                        level    <= level + firstLevel;
                        progress <= '0;
                    end
                end
                default: begin
                    state    <= STATE_IDLE;
                    level    <= '0;
                    progress <= '0;
                end
            endcase
        end
    end

    assign SC_LEVEL_SEQ_Level_Out            = level;
    assign SC_LEVEL_SEQ_Progress_Out         = progress;
    assign SC_LEVEL_SEQ_ProgressUpCount_out  = (state != STATE_SHIFT);
    assign SC_LEVEL_SEQ_LevelFinished_Out    = (state != STATE_DONE);
    assign SC_LEVEL_SEQ_FinishedGame_Out     = (state != STATE_ENDGAME);

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Scoreboard bench for sc_level_sequencer: stimulus pushes expected pulses,
// a forked monitor pops and compares them as the DUT emits them.
module tb_sc_level_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       startN = 1'b1;
    logic       t0N = 1'b1;
    logic       pauseN = 1'b1;
    logic       deathN = 1'b1;
    logic [2:0] levelOut;
    logic [4:0] progOut;
    logic       upN;
    logic       finN;
    logic       gameN;

    sc_level_sequencer #(
        .NUM_LEVELS(3), .LEVEL_WIDTH(3), .PROG_WIDTH(5), .PROG_TARGET(20)
    ) dut (
        .SC_LEVEL_SEQ_CLOCK_50(clk),
        .SC_LEVEL_SEQ_RESET_InHigh(rst),
        .SC_LEVEL_SEQ_Start_InLow(startN),
        .SC_LEVEL_SEQ_T0_InLow(t0N),
        .SC_LEVEL_SEQ_Pause_InLow(pauseN),
        .SC_LEVEL_SEQ_Death_InLow(deathN),
        .SC_LEVEL_SEQ_Level_Out(levelOut),
        .SC_LEVEL_SEQ_Progress_Out(progOut),
        .SC_LEVEL_SEQ_ProgressUpCount_out(upN),
        .SC_LEVEL_SEQ_LevelFinished_Out(finN),
        .SC_LEVEL_SEQ_FinishedGame_Out(gameN)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fin;
        logic [2:0] lvl;
        logic [4:0] prog;
    } evT;

    evT q[$];
    int nChk = 0;
    int nFail = 0;
    int nUp = 0;
    int nFin = 0;

    // Small reference model of level/progress, stepped by the stimulus.
    int  mLevel = 0;
    int  mProg = 0;
    bit  paused = 0;
    bit  ended = 0;

    task automatic chk(input string name, input int act, input int exp);
        nChk++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic tick(input int gap);
        @(negedge clk);
        t0N = 1'b0;
        if (!paused && !ended) begin
            mProg++;
            q.push_back('{fin: 1'b0, lvl: 3'(mLevel), prog: 5'(mProg)});
            if (mProg == 20) begin
                q.push_back('{fin: 1'b1, lvl: 3'(mLevel), prog: 5'(20)});
                if (mLevel == 3) ended = 1;
                else begin
                    mLevel++;
                    mProg = 0;
                end
            end
        end
        @(posedge clk);
        #1 t0N = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic doStart();
        @(negedge clk);
        startN = 1'b0;
        @(posedge clk);
        #1 startN = 1'b1;
        mLevel = 1;
        mProg = 0;
        ended = 0;
    endtask

    task automatic monitor();
        evT e;
        forever begin
            @(negedge clk);
            if (!upN) nUp++;
            if (!finN) nFin++;
            if (!upN || !finN) begin
                if (q.size() == 0) begin
                    nChk++;
                    nFail++;
                    $display("FAIL unexpected_pulse: up=%0b fin=%0b level=%0d prog=%0d, none expected",
                             upN, finN, levelOut, progOut);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", int'({upN, finN}), e.fin ? 2 : 1);
                    chk("pulse_level", int'(levelOut), int'(e.lvl));
                    chk("pulse_prog", int'(progOut), int'(e.prog));
                end
            end
        end
    endtask

    int up0, fin0;

    initial begin
        fork
            monitor();
        join_none

        // Reset then hold idle
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        sample();
        chk("rst_level", int'(levelOut), 0);
        chk("rst_prog", int'(progOut), 0);
        chk("rst_flags", int'({upN, finN, gameN}), 7);

        // Level 1 completion
        doStart();
        sample();
        chk("start_level", int'(levelOut), 1);
        chk("start_prog", int'(progOut), 0);
        up0 = nUp;
        fin0 = nFin;
        repeat (20) tick(3);
        sample();
        chk("l1_up_pulses", nUp - up0, 20);
        chk("l1_fin_pulses", nFin - fin0, 1);
        chk("l1_next_level", int'(levelOut), 2);
        chk("l1_next_prog", int'(progOut), 0);

        // Rest of the game
        repeat (40) tick(3);
        sample();
        chk("game_fin_pulses", nFin - fin0, 3);
        chk("game_over_flag", int'(gameN), 0);
        chk("game_level", int'(levelOut), 3);
        chk("game_prog", int'(progOut), 20);
        up0 = nUp;
        repeat (5) @(posedge clk);
        tick(3);
        sample();
        chk("endgame_held", int'(gameN), 0);
        chk("endgame_tick_ignored", nUp - up0, 0);
        chk("endgame_prog_held", int'(progOut), 20);

        // Restart
        doStart();
        sample();
        chk("restart_level", int'(levelOut), 1);
        chk("restart_prog", int'(progOut), 0);
        chk("restart_game_flag", int'(gameN), 1);

        // Death after 7 ticks
        repeat (7) tick(3);
        @(negedge clk);
        deathN = 1'b0;
        @(posedge clk);
        #1 deathN = 1'b1;
        sample();
        chk("death_clear_prog", int'(progOut), 7);
        sample();
        chk("death_prog", int'(progOut), 0);
        chk("death_level", int'(levelOut), 1);
        mProg = 0;

        // Pause suppresses ticks
        pauseN = 1'b0;
        paused = 1;
        up0 = nUp;
        repeat (5) tick(3);
        sample();
        chk("pause_no_pulses", nUp - up0, 0);
        chk("pause_prog", int'(progOut), 0);
        pauseN = 1'b1;
        paused = 0;

        // Death and T0 together: tick dropped
        repeat (3) tick(3);
        up0 = nUp;
        @(negedge clk);
        deathN = 1'b0;
        t0N = 1'b0;
        @(posedge clk);
        #1 begin deathN = 1'b1; t0N = 1'b1; end
        mProg = 0;
        sample();
        sample();
        chk("death_t0_no_pulse", nUp - up0, 0);
        chk("death_t0_prog", int'(progOut), 0);

        // T0 held two cycles: one tick
        up0 = nUp;
        @(negedge clk);
        t0N = 1'b0;
        mProg++;
        q.push_back('{fin: 1'b0, lvl: 3'(mLevel), prog: 5'(mProg)});
        @(posedge clk);
        @(posedge clk);
        #1 t0N = 1'b1;
        repeat (3) @(posedge clk);
        sample();
        chk("double_t0_pulses", nUp - up0, 1);
        chk("double_t0_prog", int'(progOut), 1);

        // Reset during DONE
        repeat (18) tick(3);
        fin0 = nFin;
        tick(0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sample();
        chk("rst_done_level", int'(levelOut), 0);
        chk("rst_done_prog", int'(progOut), 0);
        chk("rst_done_flags", int'({upN, finN, gameN}), 7);
        repeat (5) @(posedge clk);
        sample();
        chk("rst_done_fin_pulses", nFin - fin0, 1);
        chk("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
